// File: rtl/onehot_decoder_skid.sv
// -----------------------------------------------------------------------------
// onehot_decoder_skid
//   Streams binary indices in and one-hot lane masks out. It is the inverse of
//   the priority encoder. Both sides use valid/ready. A 2-entry registered
//   buffer (output register + skid register) gives full throughput. in_ready_o
//   depends only on registered state, so there is no combinational path from
//   out_ready_i.
//
// Parameters
//   N        number of one-hot lanes (N >= 1)
//   REVERSE  1: index i drives bit N-1-i
//   LN       index width, derived from N (do not override)
//
// Ports
//   clk_i         clock, all state on rising edge
//   reset_i       asynchronous active-high reset
//   in_valid_i    in_index_i valid
//   in_ready_o    block can accept (transfer on in_valid_i & in_ready_o)
//   in_index_i    binary index to decode
//   out_valid_o   out_onehot_o / out_error_o valid
//   out_ready_i   consumer accepts (transfer on out_valid_o & out_ready_i)
//   out_onehot_o  decoded mask, exactly one bit set unless out_error_o
//   out_error_o   captured index was >= N (mask all zero)
// -----------------------------------------------------------------------------
module onehot_decoder_skid #(
  parameter int N       = 4,
  parameter bit REVERSE = 1'b0,
  parameter int LN      = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [LN-1:0] in_index_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [N-1:0]  out_onehot_o,
  output logic          out_error_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // nothing held
    BUSY  = 2'd1,  // output register valid
    FULL  = 2'd2   // output register and skid register valid
  } state_e;

  localparam int unsigned NU = N;

  state_e       state_q, state_d;
  logic [N-1:0] out_mask_q, out_mask_d;
  logic         out_err_q, out_err_d;
  logic [N-1:0] skid_mask_q, skid_mask_d;
  logic         skid_err_q, skid_err_d;

  logic [N-1:0] dec_mask;
  logic         dec_err;
  logic         acc;
  logic         drn;

  // Decode: each lane compares the index against its own constant. An
  // out-of-range index matches no lane, so the mask is zero whenever
  // dec_err is set.
  for (genvar gi = 0; gi < N; gi++) begin : g_dec
    localparam int unsigned LANE_IDX = REVERSE ? (NU - 1 - gi) : gi;
    assign dec_mask[gi] = (32'(in_index_i) == LANE_IDX);
  end

  assign dec_err = (32'(in_index_i) >= NU);

  assign acc = in_valid_i & in_ready_o;
  assign drn = out_valid_o & out_ready_i;

  // State and data registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= EMPTY;
      out_mask_q  <= '0;
      out_err_q   <= 1'b0;
      skid_mask_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_mask_q  <= out_mask_d;
      out_err_q   <= out_err_d;
      skid_mask_q <= skid_mask_d;
      skid_err_q  <= skid_err_d;
    end
  end

  // Next-state and next-data logic. The decoded data is only captured on
  // accept, so in_index_i is ignored while in_valid_i is low.
  always_comb begin
    state_d     = state_q;
    out_mask_d  = out_mask_q;
    out_err_d   = out_err_q;
    skid_mask_d = skid_mask_q;
    skid_err_d  = skid_err_q;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d    = BUSY;
          out_mask_d = dec_mask;
          out_err_d  = dec_err;
        end
      end
      BUSY: begin
        if (acc && drn) begin
          out_mask_d = dec_mask;
          out_err_d  = dec_err;
        end else if (acc) begin
          // Consumer stalled: park the new item behind the output register.
          state_d     = FULL;
          skid_mask_d = dec_mask;
          skid_err_d  = dec_err;
        end else if (drn) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drn) begin
          state_d    = BUSY;
          out_mask_d = skid_mask_q;
          out_err_d  = skid_err_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Outputs. These are decoded from registered state only. Reset is folded
  // into in_ready_o so nothing is accepted while reset is held.
  always_comb begin
    in_ready_o  = (state_q != FULL) & ~reset_i;
    out_valid_o = (state_q != EMPTY);
  end

  assign out_onehot_o = out_mask_q;
  assign out_error_o  = out_err_q;

endmodule

// File: tb/tb_onehot_decoder_skid.sv
module tb_onehot_decoder_skid;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       out_ready;
  logic [2:0] in_index;

  // Four configurations share one stream: A N=4/R=0, B N=5/R=1, C N=8/R=0, D N=4/R=1
  logic       ir_a, ir_b, ir_c, ir_d;
  logic       ov_a, ov_b, ov_c, ov_d;
  logic [3:0] oh_a, oh_d;
  logic [4:0] oh_b;
  logic [7:0] oh_c;
  logic       er_a, er_b, er_c, er_d;

  int checks = 0;
  int errors = 0;
  int sent_cnt = 0;
  int recv_cnt = 0;
  int discard_cnt = 0;
  bit rand_ready_en = 0;
  bit verbose = 1;
  int exp_q[$];

  onehot_decoder_skid #(.N(4), .REVERSE(1'b0)) u_a (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(ir_a),
    .in_index_i(in_index[1:0]), .out_valid_o(ov_a), .out_ready_i(out_ready),
    .out_onehot_o(oh_a), .out_error_o(er_a));

  onehot_decoder_skid #(.N(5), .REVERSE(1'b1)) u_b (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(ir_b),
    .in_index_i(in_index), .out_valid_o(ov_b), .out_ready_i(out_ready),
    .out_onehot_o(oh_b), .out_error_o(er_b));

  onehot_decoder_skid #(.N(8), .REVERSE(1'b0)) u_c (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(ir_c),
    .in_index_i(in_index), .out_valid_o(ov_c), .out_ready_i(out_ready),
    .out_onehot_o(oh_c), .out_error_o(er_c));

  onehot_decoder_skid #(.N(4), .REVERSE(1'b1)) u_d (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(ir_d),
    .in_index_i(in_index[1:0]), .out_valid_o(ov_d), .out_ready_i(out_ready),
    .out_onehot_o(oh_d), .out_error_o(er_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Reference: an in-range index lights one lane (mirrored if rev), else error.
  function automatic void exp_of(input int n, input bit rev, input int idx,
                                 output logic [7:0] m, output logic e);
    if (idx < n) begin
      m = 8'd1 << (rev ? (n - 1 - idx) : idx);
      e = 1'b0;
    end else begin
      m = 8'd0;
      e = 1'b1;
    end
  endfunction

  // Monitor: samples on the falling edge. Queue depth is the model occupancy.
  always @(negedge clk) begin
    logic [7:0] m;
    logic       e;
    int         idx;
    if (reset) begin
      check("rst_in_ready", {28'd0, ir_a, ir_b, ir_c, ir_d}, 32'd0);
      check("rst_out_valid", {28'd0, ov_a, ov_b, ov_c, ov_d}, 32'd0);
      check("rst_onehot_c", {24'd0, oh_c}, 32'd0);
      discard_cnt += exp_q.size();
      exp_q.delete();
    end else begin
      check("in_ready", {28'd0, ir_a, ir_b, ir_c, ir_d},
            (exp_q.size() < 2) ? 32'hF : 32'h0);
      check("out_valid", {28'd0, ov_a, ov_b, ov_c, ov_d},
            (exp_q.size() > 0) ? 32'hF : 32'h0);
      if (ov_c && exp_q.size() > 0) begin
        idx = exp_q[0];
        exp_of(4, 1'b0, idx & 3, m, e);
        check("a_onehot", {28'd0, oh_a}, {24'd0, m});
        check("a_error", {31'd0, er_a}, {31'd0, e});
        exp_of(5, 1'b1, idx, m, e);
        check("b_onehot", {27'd0, oh_b}, {24'd0, m});
        check("b_error", {31'd0, er_b}, {31'd0, e});
        exp_of(8, 1'b0, idx, m, e);
        check("c_onehot", {24'd0, oh_c}, {24'd0, m});
        check("c_error", {31'd0, er_c}, {31'd0, e});
        exp_of(4, 1'b1, idx & 3, m, e);
        check("d_onehot", {28'd0, oh_d}, {24'd0, m});
        check("d_error", {31'd0, er_d}, {31'd0, e});
        if (out_ready) begin
          if (verbose)
            $display("OUT idx=%0d a=%b b=%b/%b c=%b d=%b", idx, oh_a, oh_b, er_b, oh_c, oh_d);
          void'(exp_q.pop_front());
          recv_cnt++;
        end
      end
    end
  end

  // Random consumer backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready_en) out_ready = ($urandom_range(0, 99) < 60);
    end
  end

  task automatic send(input int idx);
    int waited;
    bit done;
    waited = 0;
    done = 0;
    in_valid = 1'b1;
    in_index = 3'(idx);
    while (!done) begin
      @(negedge clk);
      #1;
      if (ir_c && !reset) begin
        exp_q.push_back(idx);
        sent_cnt++;
        if (verbose) $display("IN  idx=%0d", idx);
        done = 1;
      end else if (++waited > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout idx=%0d actual=stalled required=accepted", idx);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_index = 3'($urandom);
  endtask

  task automatic wait_empty();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 500) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_index  = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Back-to-back, no backpressure
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(i);
    wait_empty();

    // Reverse mapping endpoints, then out-of-range indices and top lane of N=5
    send(0);
    send(3);
    for (int i = 5; i < 8; i++) send(i);
    send(4);
    wait_empty();

    // Backpressure: third item must stall until the consumer drains
    out_ready = 1'b0;
    send(1);
    send(2);
    in_valid = 1'b1;
    in_index = 3'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("stall_in_ready", {31'd0, ir_c}, 32'd0);
      check("stall_onehot", {24'd0, oh_c}, 32'h02);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(3);
    wait_empty();

    // Reset while FULL
    out_ready = 1'b0;
    send(2);
    send(6);
    #2;
    reset = 1'b1;
    #1;
    check("async_out_valid", {31'd0, ov_c}, 32'd0);
    check("async_onehot", {24'd0, oh_c}, 32'd0);
    check("async_in_ready", {31'd0, ir_c}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    send(5);
    wait_empty();

    // Random valid/ready
    verbose = 0;
    rand_ready_en = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send($urandom_range(0, 7));
    end
    rand_ready_en = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_empty();

    check("no_loss", 32'(recv_cnt + discard_cnt), 32'(sent_cnt));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
